ocl_multi_fifo_regs: RTL and testbench
======================================

// Module: ocl_multi_fifo_regs
// PURPOSE
//  AXI-Lite (OCL BAR0) slave exposing NUM_CH independent local FIFOs as memory-mapped registers.
//  Host pushes by writing DATA, pops by reading DATA; per-channel STATUS/THRESH/CTRL registers.
//  Sits behind the OCL AXI-L register slice; replaces the single fixed-width local FIFO.
//  Adds per-channel flush, almost-full threshold, sticky overflow/underflow and error responses.
// PARAMETERS
//  NUM_CH      4    number of FIFO channels (1..16)
//  DATA_W      32   FIFO entry width (1..32); reads zero-extend to 32 bits
//  DEPTH       16   entries per channel; power of two, 2..1024
//  UNIMPL_VAL  32'hDEAD_BEEF  read data for unmapped addresses
// PORTS
//  clk_main_a0   in   1        clock
//  rst_main_n    in   1        reset, asynchronous, active-low
//  awvalid/awready in/out 1    write address handshake; awaddr in 32
//  wvalid/wready in/out 1      write data handshake; wdata in 32; wstrb in 4 (ignored, full-word)
//  bvalid/bready out/in 1      write response; bresp out 2
//  arvalid/arready in/out 1    read address handshake; araddr in 32
//  rvalid/rready out/in 1      read response; rdata out 32; rresp out 2
//  fifo_empty    out  NUM_CH   per-channel empty
//  fifo_full     out  NUM_CH   per-channel full
//  fifo_afull    out  NUM_CH   per-channel count >= THRESH
//  fifo_count    out  NUM_CH*16 per-channel occupancy, channel c at [16c+15:16c]
// BEHAVIOUR
//  Address map: ch = awaddr/araddr[7:4]; off = [3:0]; [31:8] must be 0 and ch < NUM_CH, else unmapped.
//   +0x0 DATA  W: push wdata[DATA_W-1:0]; R: pop head entry
//   +0x4 STATUS R: [15:0] count, [16] empty, [17] full, [18] afull, [19] ovf sticky, [20] udf sticky
//   +0x8 THRESH R/W: [15:0] almost-full threshold; reset DEPTH-1
//   +0xC CTRL  W: bit0 flush (count->0, ptrs->0), bit1 clear ovf/udf sticky; R: 0
//  Reset (async assert, sync deassert via 2-flop synchroniser): all ptrs/counts 0, stickies 0,
//   THRESH=DEPTH-1; awready=wready=arready=bvalid=rvalid=0; bresp=rresp=0; rdata=0.
//  FSM states: IDLE, WRESP, RDATA. One transaction in flight at a time.
//   IDLE: if awvalid&&wvalid -> awready=wready=1 for one cycle, perform write, -> WRESP.
//         else if arvalid -> arready=1 for one cycle, register rdata/rresp, perform pop, -> RDATA.
//         Write wins when both pending in the same cycle. aw without w: wait, no ready asserted.
//   WRESP: bvalid=1 held until bready; then -> IDLE. RDATA: rvalid=1 held until rready; then -> IDLE.
//  Latency: bvalid/rvalid assert the cycle after the address handshake; back-to-back ops >= 2 cycles.
//  Push to full channel: entry dropped, ovf sticky set, bresp=2'b10 (SLVERR); otherwise OKAY.
//  Pop from empty channel: rdata=0, udf sticky set, rresp=2'b10, pointers unchanged.
//  Unmapped write: ignored, bresp=2'b10. Unmapped read: rdata=UNIMPL_VAL, rresp=2'b10.
//  Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits, 0..DEPTH.
//  Flush and clear-sticky take effect in the write cycle; both may be set in one write.
//  THRESH value 0 makes afull always 1; values > DEPTH make afull never assert.
//  Status outputs are registered and update the cycle after a push/pop/flush.
//  Reset mid-transaction: FSM returns to IDLE, any pending response is discarded, FIFO contents lost.
// TESTING
//  1 Reset: deassert rst_main_n -> all fifo_empty=1, fifo_count=0, STATUS ch0 reads 32'h0001_0000.
//  2 Push 0x11,0x22,0x33 to ch1 DATA (0x10) -> count=3; three reads of 0x10 return 0x11,0x22,0x33 OKAY.
//  3 Fill ch0 with DEPTH writes, one more write -> bresp=SLVERR, STATUS bit19=1, full=1, first
//    pop returns first value written; write CTRL=0x2 -> bit19 cleared.
//  4 Read ch2 DATA when empty -> rdata=0, rresp=SLVERR, STATUS bit20=1; push/pop across >DEPTH
//    entries verifies pointer wrap with incrementing data pattern.
//  5 THRESH ch3=4; push 4 -> fifo_afull[3]=1 after 4th push; CTRL=0x1 flush -> count 0, empty=1.
//  6 awvalid+wvalid and arvalid same cycle -> write accepted first, read accepted after bready;
//    read of 0x100 (unmapped) -> rdata=32'hDEAD_BEEF, rresp=SLVERR; rready held low 10 cycles ->
//    rvalid and rdata stable throughout.

Source files
------------

// File: rtl/ocl_multi_fifo_regs.sv
// AXI-Lite register slave exposing NUM_CH independent FIFOs (push on DATA write, pop on DATA read)
// with per-channel STATUS, almost-full THRESH and CTRL (flush / clear sticky) registers.
module ocl_multi_fifo_regs #(
  parameter int          NUM_CH     = 4,
  parameter int          DATA_W     = 32,
  parameter int          DEPTH      = 16,
  parameter logic [31:0] UNIMPL_VAL = 32'hDEAD_BEEF
) (
  input  logic                   clk_main_a0,
  input  logic                   rst_main_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [31:0]            awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [31:0]            wdata,
  input  logic [3:0]             wstrb,
  output logic                   bvalid,
  input  logic                   bready,
  output logic [1:0]             bresp,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [31:0]            araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [31:0]            rdata,
  output logic [1:0]             rresp,
  output logic [NUM_CH-1:0]      fifo_empty,
  output logic [NUM_CH-1:0]      fifo_full,
  output logic [NUM_CH-1:0]      fifo_afull,
  output logic [NUM_CH*16-1:0]   fifo_count,
  output logic [1:0]             dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Handshake: a request is taken only in IDLE; awready/wready (or arready) pulse for the single
  // cycle in which valid is seen, and bvalid/rvalid then hold until the host's ready is sampled.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WRESP = 2'd1, S_RDATA = 2'd2} state_t;

  state_t state_q, state_d;
  logic [1:0] rst_sync;
  logic       rst_n;
  logic       wr_fire, rd_fire;
  logic       unused_bits;

  logic [DATA_W-1:0] mem    [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr [NUM_CH];
  logic [CNT_W-1:0]  count  [NUM_CH];
  logic [15:0]       thresh [NUM_CH];
  logic [NUM_CH-1:0] ovf, udf;

  logic            wr_map, rd_map;
  logic [CH_W-1:0] wr_ch, rd_ch;
  logic            push_ok, push_ovf, thresh_we, ctrl_we, wr_err;
  logic            pop_ok, pop_udf, rd_err;
  logic [31:0]     rd_word;

  assign unused_bits = ^{wstrb, wdata};

  // Reset asserts asynchronously and releases two clocks later, synchronous to clk_main_a0.
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) rst_sync <= 2'b00;
    else             rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign wr_map = (awaddr[31:8] == 24'd0) && (32'(awaddr[7:4]) < 32'(NUM_CH)) && (awaddr[1:0] == 2'b00);
  assign rd_map = (araddr[31:8] == 24'd0) && (32'(araddr[7:4]) < 32'(NUM_CH)) && (araddr[1:0] == 2'b00);
  assign wr_ch  = awaddr[4 +: CH_W];
  assign rd_ch  = araddr[4 +: CH_W];

  always_comb begin
    state_d = state_q;
    awready = 1'b0;
    wready  = 1'b0;
    arready = 1'b0;
    wr_fire = 1'b0;
    rd_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rst_n && awvalid && wvalid) begin
          awready = 1'b1;
          wready  = 1'b1;
          wr_fire = 1'b1;
          state_d = S_WRESP;
        end else if (rst_n && arvalid) begin
          arready = 1'b1;
          rd_fire = 1'b1;
          state_d = S_RDATA;
        end
      end
      S_WRESP: if (bready) state_d = S_IDLE;
      S_RDATA: if (rready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bvalid    = (state_q == S_WRESP);
  assign rvalid    = (state_q == S_RDATA);
  assign dbg_state = state_q;

  always_comb begin
    push_ok   = 1'b0;
    push_ovf  = 1'b0;
    thresh_we = 1'b0;
    ctrl_we   = 1'b0;
    wr_err    = !wr_map;
    if (wr_map) begin
      case (awaddr[3:2])
        2'd0: begin
          push_ok  = wr_fire && (count[wr_ch] != FULL_CNT);
          push_ovf = wr_fire && (count[wr_ch] == FULL_CNT);
          wr_err   = (count[wr_ch] == FULL_CNT);
        end
        2'd2:    thresh_we = wr_fire;
        2'd3:    ctrl_we   = wr_fire;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_word = UNIMPL_VAL;
    rd_err  = 1'b1;
    pop_ok  = 1'b0;
    pop_udf = 1'b0;
    if (rd_map) begin
      rd_err = 1'b0;
      case (araddr[3:2])
        2'd0: begin
          if (count[rd_ch] == '0) begin
            rd_word = 32'd0;
            rd_err  = 1'b1;
            pop_udf = rd_fire;
          end else begin
            rd_word = 32'(mem[rd_ch][rd_ptr[rd_ch]]);
            pop_ok  = rd_fire;
          end
        end
        2'd1:    rd_word = {11'd0, udf[rd_ch], ovf[rd_ch], fifo_afull[rd_ch], fifo_full[rd_ch],
                            fifo_empty[rd_ch], 16'(count[rd_ch])};
        2'd2:    rd_word = {16'd0, thresh[rd_ch]};
        default: rd_word = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk_main_a0 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bresp   <= RESP_OKAY;
      rresp   <= RESP_OKAY;
      rdata   <= 32'd0;
      ovf     <= '0;
      udf     <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
        thresh[c] <= 16'(DEPTH - 1);
      end
    end else begin
      state_q <= state_d;
      if (wr_fire) bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
      if (rd_fire) begin
        rdata <= rd_word;
        rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
      if (push_ok) begin
        wr_ptr[wr_ch] <= wr_ptr[wr_ch] + 1'b1;
        count[wr_ch]  <= count[wr_ch] + 1'b1;
      end
      if (push_ovf)  ovf[wr_ch]    <= 1'b1;
      if (thresh_we) thresh[wr_ch] <= wdata[15:0];
      if (ctrl_we && wdata[0]) begin
        wr_ptr[wr_ch] <= '0;
        rd_ptr[wr_ch] <= '0;
        count[wr_ch]  <= '0;
      end
      if (ctrl_we && wdata[1]) begin
        ovf[wr_ch] <= 1'b0;
        udf[wr_ch] <= 1'b0;
      end
      if (pop_ok) begin
        rd_ptr[rd_ch] <= rd_ptr[rd_ch] + 1'b1;
        count[rd_ch]  <= count[rd_ch] - 1'b1;
      end
      if (pop_udf) udf[rd_ch] <= 1'b1;
    end
  end

  // Entry storage carries no reset; occupancy is tracked only by the pointers and counts.
  always_ff @(posedge clk_main_a0) begin
    if (push_ok) mem[wr_ch][wr_ptr[wr_ch]] <= wdata[DATA_W-1:0];
  end

  always_comb begin
    fifo_empty = '0;
    fifo_full  = '0;
    fifo_afull = '0;
    fifo_count = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      fifo_empty[c]         = (count[c] == '0);
      fifo_full[c]          = (count[c] == FULL_CNT);
      fifo_afull[c]         = (16'(count[c]) >= thresh[c]);
      fifo_count[16*c +: 16] = 16'(count[c]);
    end
  end

endmodule

// File: tb/tb_ocl_multi_fifo_regs.sv
// Bench for ocl_multi_fifo_regs: directed scenarios plus random register traffic checked against
// a queue-based model of each channel.
module tb_ocl_multi_fifo_regs;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst_main_n;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp, dbg_state;
  logic [NUM_CH-1:0] fifo_empty, fifo_full, fifo_afull;
  logic [NUM_CH*16-1:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mq [NUM_CH][$];
  int          m_thresh [NUM_CH];
  bit          m_ovf [NUM_CH];
  bit          m_udf [NUM_CH];

  always #5 clk = ~clk;

  ocl_multi_fifo_regs #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .UNIMPL_VAL(32'hDEAD_BEEF)) dut (
    .clk_main_a0(clk), .rst_main_n(rst_main_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_afull(fifo_afull),
    .fifo_count(fifo_count), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic m_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      mq[c].delete();
      m_thresh[c] = DEPTH - 1;
      m_ovf[c] = 0;
      m_udf[c] = 0;
    end
  endtask

  function automatic bit m_mapped(input logic [31:0] a);
    return (a[31:8] == 0) && (int'(a[7:4]) < NUM_CH) && (a[1:0] == 0);
  endfunction

  function automatic logic [31:0] m_status(input int ch);
    int n;
    logic [31:0] s;
    n = mq[ch].size();
    s = 32'(n);
    s[16] = (n == 0);
    s[17] = (n == DEPTH);
    s[18] = (n >= m_thresh[ch]);
    s[19] = m_ovf[ch];
    s[20] = m_udf[ch];
    return s;
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] r);
    int ch;
    r = 2'b00;
    if (!m_mapped(a)) begin r = 2'b10; return; end
    ch = int'(a[7:4]);
    case (a[3:2])
      2'd0: if (mq[ch].size() == DEPTH) begin m_ovf[ch] = 1; r = 2'b10; end
            else mq[ch].push_back(d);
      2'd2: m_thresh[ch] = int'(d[15:0]);
      2'd3: begin
        if (d[0]) mq[ch].delete();
        if (d[1]) begin m_ovf[ch] = 0; m_udf[ch] = 0; end
      end
      default: ;
    endcase
  endtask

  task automatic m_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    int ch;
    r = 2'b00;
    d = 32'd0;
    if (!m_mapped(a)) begin d = 32'hDEAD_BEEF; r = 2'b10; return; end
    ch = int'(a[7:4]);
    case (a[3:2])
      2'd0: if (mq[ch].size() == 0) begin m_udf[ch] = 1; r = 2'b10; end
            else d = mq[ch].pop_front();
      2'd1: d = m_status(ch);
      2'd2: d = 32'(m_thresh[ch]);
      default: d = 32'd0;
    endcase
  endtask

  task automatic chk_outputs(input string tag);
    logic [NUM_CH*16-1:0] ec;
    logic [NUM_CH-1:0] ee, ef, ea;
    for (int c = 0; c < NUM_CH; c++) begin
      ec[16*c +: 16] = 16'(mq[c].size());
      ee[c] = (mq[c].size() == 0);
      ef[c] = (mq[c].size() == DEPTH);
      ea[c] = (mq[c].size() >= m_thresh[c]);
    end
    chk({tag, "_count"}, 64'(fifo_count), 64'(ec));
    chk({tag, "_empty"}, 64'(fifo_empty), 64'(ee));
    chk({tag, "_full"},  64'(fifo_full),  64'(ef));
    chk({tag, "_afull"}, 64'(fifo_afull), 64'(ea));
  endtask

  // ---------------- bus drivers ----------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
    int n;
    awaddr = a; wdata = d; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    #1;
    n = 0;
    while (awready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    chk("aw_accept", 64'(awready & wready), 64'd1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    chk("bvalid_latency", 64'(bvalid), 64'd1);
    n = 0;
    while (bvalid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    resp = bresp;
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1;
    #1;
    n = 0;
    while (arready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    chk("ar_accept", 64'(arready), 64'd1);
    @(posedge clk); #1;
    arvalid = 0;
    chk("rvalid_latency", 64'(rvalid), 64'd1);
    n = 0;
    while (rvalid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    d = rdata; resp = rresp;
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d);
    logic [1:0] got, exp;
    m_write(a, d, exp);
    bus_write(a, d, got);
    chk({tag, "_bresp"}, 64'(got), 64'(exp));
  endtask

  task automatic rd(input string tag, input logic [31:0] a, output logic [31:0] got_d);
    logic [1:0] got_r, exp_r;
    logic [31:0] exp_d;
    m_read(a, exp_d, exp_r);
    bus_read(a, got_d, got_r);
    chk({tag, "_rdata"}, 64'(got_d), 64'(exp_d));
    chk({tag, "_rresp"}, 64'(got_r), 64'(exp_r));
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] a;
    int ch, op;

    awvalid = 1; wvalid = 1; arvalid = 1; bready = 0; rready = 0;
    awaddr = 32'h10; wdata = 32'h5; wstrb = 4'hF; araddr = 32'h0;
    rst_main_n = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_bvalid",  64'(bvalid),  64'd0);
    chk("rst_rvalid",  64'(rvalid),  64'd0);
    chk("rst_rdata",   64'(rdata),   64'd0);
    chk("rst_bresp",   64'(bresp),   64'd0);
    awvalid = 0; wvalid = 0; arvalid = 0;
    rst_main_n = 1;
    repeat (4) @(posedge clk);
    #1;
    chk_outputs("reset");
    rd("rst_status0", 32'h04, v);
    chk("rst_status0_const", 64'(v), 64'h0001_0000);

    // Basic push/pop on channel 1
    wr("t2_push", 32'h10, 32'h11);
    wr("t2_push", 32'h10, 32'h22);
    wr("t2_push", 32'h10, 32'h33);
    chk("t2_count3", 64'(fifo_count[31:16]), 64'd3);
    rd("t2_pop", 32'h10, v); chk("t2_v0", 64'(v), 64'h11);
    rd("t2_pop", 32'h10, v); chk("t2_v1", 64'(v), 64'h22);
    rd("t2_pop", 32'h10, v); chk("t2_v2", 64'(v), 64'h33);
    chk_outputs("t2");

    // Fill channel 0, overflow, clear sticky
    for (int i = 0; i < DEPTH; i++) wr("t3_fill", 32'h00, 32'hA000 + 32'(i));
    wr("t3_ovf", 32'h00, 32'hFFFF);
    chk_outputs("t3_full");
    rd("t3_status", 32'h04, v);
    chk("t3_ovf_bit", 64'(v[19]), 64'd1);
    rd("t3_first", 32'h00, v);
    chk("t3_first_const", 64'(v), 64'hA000);
    wr("t3_clr", 32'h0C, 32'h2);
    rd("t3_status2", 32'h04, v);
    chk("t3_ovf_clr", 64'(v[19]), 64'd0);
    rd("t3_ctrl_rd", 32'h0C, v);

    // Underflow on channel 2, then wrap pointers
    rd("t4_udf", 32'h20, v);
    rd("t4_status", 32'h24, v);
    chk("t4_udf_bit", 64'(v[20]), 64'd1);
    for (int i = 0; i < 10; i++) wr("t4_pre", 32'h20, 32'(i));
    for (int i = 10; i < 45; i++) begin
      wr("t4_wrap_push", 32'h20, 32'(i));
      rd("t4_wrap_pop", 32'h20, v);
    end
    chk_outputs("t4");

    // Threshold and flush on channel 3
    wr("t5_thresh", 32'h38, 32'd4);
    for (int i = 0; i < 3; i++) wr("t5_push", 32'h30, 32'h300 + 32'(i));
    chk("t5_afull_3", 64'(fifo_afull[3]), 64'd0);
    wr("t5_push", 32'h30, 32'h303);
    chk("t5_afull_4", 64'(fifo_afull[3]), 64'd1);
    wr("t5_flush", 32'h3C, 32'h1);
    chk("t5_cnt0", 64'(fifo_count[63:48]), 64'd0);
    chk("t5_empty", 64'(fifo_empty[3]), 64'd1);
    wr("t5_thresh0", 32'h38, 32'd0);
    chk("t5_afull_t0", 64'(fifo_afull[3]), 64'd1);
    wr("t5_thresh_big", 32'h38, 32'd17);
    chk_outputs("t5");

    // Simultaneous write and read; write first, unmapped read held with rready low
    begin
      logic [1:0] er;
      logic [31:0] ed;
      awaddr = 32'h10; wdata = 32'h66; awvalid = 1; wvalid = 1;
      araddr = 32'h100; arvalid = 1;
      #1;
      chk("t6_aw_first", 64'(awready), 64'd1);
      chk("t6_ar_wait", 64'(arready), 64'd0);
      m_write(32'h10, 32'h66, er);
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0;
      chk("t6_bvalid", 64'(bvalid), 64'd1);
      chk("t6_bresp", 64'(bresp), 64'(er));
      repeat (2) begin @(posedge clk); #1; end
      chk("t6_ar_blocked", 64'(arready), 64'd0);
      chk("t6_bvalid_hold", 64'(bvalid), 64'd1);
      bready = 1;
      @(posedge clk); #1;
      bready = 0;
      chk("t6_bvalid_drop", 64'(bvalid), 64'd0);
      chk("t6_ar_accept", 64'(arready), 64'd1);
      @(posedge clk); #1;
      arvalid = 0;
      m_read(32'h100, ed, er);
      for (int i = 0; i < 10; i++) begin
        chk("t6_rvalid_hold", 64'(rvalid), 64'd1);
        chk("t6_rdata_hold", 64'(rdata), 64'(ed));
        chk("t6_rresp_hold", 64'(rresp), 64'(er));
        @(posedge clk); #1;
      end
      chk("t6_unimpl", 64'(rdata), 64'hDEAD_BEEF);
      rready = 1;
      @(posedge clk); #1;
      rready = 0;
      chk("t6_rvalid_drop", 64'(rvalid), 64'd0);
      chk_outputs("t6");
    end

    // Random register traffic
    for (int i = 0; i < 200; i++) begin
      ch = $urandom_range(0, NUM_CH - 1);
      op = $urandom_range(0, 19);
      a  = {24'd0, 4'(ch), 4'd0};
      if (op < 7)       wr("rnd_push", a, $urandom);
      else if (op < 13) rd("rnd_pop", a, v);
      else if (op < 15) rd("rnd_status", a | 32'h4, v);
      else if (op == 15) wr("rnd_thresh", a | 32'h8, 32'($urandom_range(0, DEPTH + 2)));
      else if (op == 16) wr("rnd_ctrl", a | 32'hC, ($urandom_range(0, 7) == 0) ? 32'h3 : 32'h2);
      else if (op == 17) rd("rnd_thresh_rd", a | 32'h8, v);
      else if (op == 18) wr("rnd_unmapped_w", 32'h100 | 32'($urandom_range(0, 15)) << 4, $urandom);
      else               rd("rnd_unmapped_r", {20'h1, 4'd0, 4'($urandom_range(4, 15)), 4'd0}, v);
      if (i % 10 == 0) chk_outputs("rnd");
    end
    chk_outputs("rnd_end");

    // Reset while a write response is pending
    wr("mr_push", 32'h30, 32'h77);
    awaddr = 32'h30; wdata = 32'h78; awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    rst_main_n = 0;
    #1;
    chk("mr_bvalid", 64'(bvalid), 64'd0);
    chk("mr_count", 64'(fifo_count), 64'd0);
    chk("mr_empty", 64'(fifo_empty), 64'hF);
    @(posedge clk); #1;
    rst_main_n = 1;
    m_reset();
    repeat (4) begin @(posedge clk); #1; end
    rd("mr_status", 32'h34, v);
    rd("mr_thresh", 32'h38, v);
    chk("mr_thresh_const", 64'(v), 64'(DEPTH - 1));
    chk_outputs("mr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
